ddr3_cmd_fifo: RTL
==================

// Module: ddr3_cmd_fifo
// PURPOSE
//  Command queue upstream of the DDR3 processing logic. Host pushes 34-bit words {cmd[33:31], addr[30:5], rsvd[4:0]}.
//  Controller pops one word with a single-cycle CMD_get pulse; the popped word is registered on CMD_data_out.
//  CMD_data_out holds until the next accepted pop, so the controller may sample it across a whole transaction.
// PARAMETERS
//  WIDTH       34  word width (cmd 3b, bank 3b, row 13b, col 10b, rsvd 5b)
//  DEPTH_LOG2  3   log2 of entry count (8 entries)
//  AF_LEVEL    6   occupancy at or above which cmd_almost_full=1 (only with CMD_FIFO_ERR_EN)
// PORTS
//  clk             in   1           system clock, all logic on posedge
//  reset           in   1           asynchronous, active-high; clears all state
//  cmd_put         in   1           host write strobe, one word per cycle
//  cmd_data_in     in   WIDTH       host write data
//  cmd_full        out  1           no free entry
//  CMD_get         in   1           controller pop strobe
//  CMD_empty       out  1           no stored entry
//  CMD_data_out    out  WIDTH       last popped word, registered
//  cmd_count       out  DEPTH_LOG2+1 current occupancy, 0..2**DEPTH_LOG2
// BEHAVIOUR
//  - Storage: 2**DEPTH_LOG2 x WIDTH array. wr_ptr/rd_ptr are DEPTH_LOG2 bits wide and wrap naturally mod depth.
//    Array contents are not reset.
//  - Reset (async assert, sync release): wr_ptr=0, rd_ptr=0, cmd_count=0, CMD_empty=1, cmd_full=0,
//    CMD_data_out=0, error flags=0.
//  - Push accepted iff cmd_put && (!cmd_full || pop_acc). Writes mem[wr_ptr], wr_ptr+1.
//  - Pop accepted iff CMD_get && !CMD_empty. CMD_data_out<=mem[rd_ptr] on that edge (valid 1 cycle after
//    the get pulse), rd_ptr+1.
//  - Rejected pop (empty): no pointer change, CMD_data_out holds its previous value.
//  - Rejected push (full, no simultaneous pop): word dropped, no state change.
//  - Simultaneous push+pop:
//    - Full: both are accepted and count stays at max.
//    - Empty: the pop is rejected, the push is accepted, and count becomes 1.
//      No fall-through: the word is not visible on CMD_data_out until a later pop.
//    - Otherwise: both are accepted and count is unchanged.
//  - cmd_count: +1 on push only, -1 on pop only, unchanged when both or neither occur.
//    Arithmetic is in DEPTH_LOG2+1 bits, with no wrap past depth.
//  - CMD_empty = (cmd_count==0) and cmd_full = (cmd_count==2**DEPTH_LOG2). Both are registered, updated in the
//    same edge as the count, and never asserted together.
//  - Latency: a push at edge N is poppable at edge N+1. Its data is on CMD_data_out after the pop edge.
//  - A held CMD_get pops one word per cycle until empty. The controller is responsible for pulsing it.
//  - Reset mid-operation: queue discarded and outputs return to reset values immediately. The first push
//    after release lands at mem[0].
// CONFIGURATION
//  CMD_FIFO_ERR_EN defined:
//    - Adds outputs cmd_almost_full (1b, = cmd_count>=AF_LEVEL, registered), cmd_overflow (1b) and
//      cmd_underflow (1b).
//    - cmd_overflow is sticky, set on a rejected push. cmd_underflow is sticky, set on a rejected pop.
//    - Both are cleared only by reset.
//  CMD_FIFO_ERR_EN undefined:
//    - Those three ports and their logic do not exist.
//    - Rejected push/pop behaviour is identical but silent.
// TESTING
//  1 Reset, then push 0x1_0000_0020 (SCR), then pulse CMD_get ->
//    count 1->0, CMD_empty 0->1, CMD_data_out=0x1_0000_0020 one cycle after the get and held 50 cycles.
//  2 Push 8 words A0..A7, then push A8 -> cmd_full=1 after the 8th push, A8 dropped (cmd_overflow=1 with _EN),
//    8 pops return A0..A7 in order.
//  3 Fill to 8, then assert cmd_put and CMD_get in one cycle with B0 -> count stays 8, CMD_data_out=A0,
//    and B0 is popped last.
//  4 Empty queue, simultaneous cmd_put(C0) and CMD_get -> count=1, CMD_data_out unchanged (0),
//    the next get yields C0. A get on empty sets cmd_underflow=1 with _EN.
//  5 Run 20 push/pop pairs with 3 entries outstanding (pointer wrap) -> data order preserved, count constant at 3.
//  6 Assert reset mid-fill with count=5 -> same-cycle outputs: count=0, CMD_empty=1, CMD_data_out=0.
//    The next push/pop returns the new word, not stale data.

Source files
------------

// File: rtl/ddr3_cmd_fifo.sv
// Command queue feeding the DDR3 controller: host pushes words, controller pops into a held output register.
// Optional error/status outputs (cmd_almost_full, cmd_overflow, cmd_underflow) are built when CMD_FIFO_ERR_EN is defined.
module ddr3_cmd_fifo #(
    parameter int WIDTH      = 34,
`ifdef CMD_FIFO_ERR_EN
    parameter int AF_LEVEL   = 6,
`endif
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_put,
    input  logic [WIDTH-1:0]      cmd_data_in,
    output logic                  cmd_full,
    input  logic                  CMD_get,
    output logic                  CMD_empty,
    output logic [WIDTH-1:0]      CMD_data_out,
`ifdef CMD_FIFO_ERR_EN
    output logic                  cmd_almost_full,
    output logic                  cmd_overflow,
    output logic                  cmd_underflow,
`endif
    output logic [DEPTH_LOG2:0]   cmd_count
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count_next;
    logic                  push_acc;
    logic                  pop_acc;

    // A pop frees a slot in the same edge, so a full queue can still take a push alongside it.
    assign pop_acc  = CMD_get && !CMD_empty;
    assign push_acc = cmd_put && (!cmd_full || pop_acc);

    always_comb begin
        // NOTE: default first so every path assigns count_next and no latch is inferred.
        count_next = cmd_count;
        unique case ({push_acc, pop_acc})
            2'b10:   count_next = cmd_count + 1'b1;
            2'b01:   count_next = cmd_count - 1'b1;
            default: count_next = cmd_count;
        endcase
    end

    // NOTE: storage has no reset; occupancy and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr] <= cmd_data_in;
        end
    end

    // NOTE: non-blocking assignments keep every register sampling the pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            cmd_count    <= '0;
            CMD_empty    <= 1'b1;
            cmd_full     <= 1'b0;
            CMD_data_out <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_acc) begin
                rd_ptr       <= rd_ptr + 1'b1;
                CMD_data_out <= mem[rd_ptr];
            end
            cmd_count <= count_next;
            CMD_empty <= (count_next == '0);
            cmd_full  <= (count_next == FULL_COUNT);
        end
    end

`ifdef CMD_FIFO_ERR_EN
    // Overflow/underflow are sticky diagnostics; only reset clears them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_almost_full <= 1'b0;
            cmd_overflow    <= 1'b0;
            cmd_underflow   <= 1'b0;
        end else begin
            cmd_almost_full <= (count_next >= (DEPTH_LOG2 + 1)'(AF_LEVEL));
            if (cmd_put && !push_acc) begin
                cmd_overflow <= 1'b1;
            end
            if (CMD_get && !pop_acc) begin
                cmd_underflow <= 1'b1;
            end
        end
    end
`endif

endmodule
